// File: rtl/pwm_capture.sv
// PWM receiver: synchronises an asynchronous PWM pin and measures period, high time and duty.
// Duty is high_time * 2^WIDTH / period, computed by a multi-cycle restoring divider.
module pwm_capture #(
   parameter int WIDTH       = 8,
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             pwm_in,
   output logic [WIDTH-1:0] duty_cycle,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             busy,
   output logic             stuck_high,
   output logic             stuck_low,
   output logic             overrun
);

   typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS, STUCK} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam int               DCW       = $clog2(WIDTH + 2);
   localparam logic [DCW-1:0]   DIV_ITERS = DCW'(WIDTH + 1);

   state_t                   state_q, state_d;
   logic [SYNC_STAGES-1:0]   sync_q;
   logic                     lvl_q;
   logic [CNT_W-1:0]         per_cnt_q, per_cnt_d, high_cnt_q, high_cnt_d;
   logic [CNT_W-1:0]         per_hold_q, per_hold_d, high_hold_q, high_hold_d;
   logic [CNT_W-1:0]         dvs_q, dvs_d;
   logic [CNT_W:0]           rem_q, rem_d, rem_sub;
   logic [WIDTH:0]           quo_q, quo_d, quo_next;
   logic [DCW-1:0]           div_cnt_q, div_cnt_d;
   logic [WIDTH-1:0]         duty_q, duty_d;
   logic [CNT_W-1:0]         period_q, period_d, high_time_q, high_time_d;
   logic                     valid_q, valid_d;
   logic                     stuck_high_q, stuck_high_d, stuck_low_q, stuck_low_d;
   logic                     overrun_q, overrun_d;
   logic                     level, rise, div_ge, div_busy, sat_hit;

   function automatic logic [WIDTH-1:0] sat_duty(input logic [WIDTH:0] q);
      return q[WIDTH] ? {WIDTH{1'b1}} : q[WIDTH-1:0];
   endfunction

   assign level    = sync_q[SYNC_STAGES-1];
   assign rise     = level & ~lvl_q;
   assign div_busy = (div_cnt_q != '0);

   // One restoring step: the remainder always stays below the divisor, so the shift never overflows
   assign div_ge   = (rem_q >= {1'b0, dvs_q});
   assign rem_sub  = div_ge ? (rem_q - {1'b0, dvs_q}) : rem_q;
   assign quo_next = {quo_q[WIDTH-1:0], div_ge};

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      per_cnt_d    = per_cnt_q;
      high_cnt_d   = high_cnt_q;
      per_hold_d   = per_hold_q;
      high_hold_d  = high_hold_q;
      dvs_d        = dvs_q;
      rem_d        = rem_q;
      quo_d        = quo_q;
      div_cnt_d    = div_cnt_q;
      duty_d       = duty_q;
      period_d     = period_q;
      high_time_d  = high_time_q;
      valid_d      = 1'b0;
      stuck_high_d = stuck_high_q;
      stuck_low_d  = stuck_low_q;
      overrun_d    = overrun_q;
      sat_hit      = 1'b0;

      if (div_busy) begin
         rem_d     = rem_sub << 1;
         quo_d     = quo_next;
         div_cnt_d = div_cnt_q - 1'b1;
         if (div_cnt_q == DCW'(1)) begin
            duty_d      = sat_duty(quo_next);
            period_d    = per_hold_q;
            high_time_d = high_hold_q;
            valid_d     = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            per_cnt_d  = '0;
            high_cnt_d = '0;
            if (enable) state_d = WAIT_RISE;
         end
         WAIT_RISE: begin
            if (rise) begin
               state_d    = MEAS;
               per_cnt_d  = CNT_W'(1);
               high_cnt_d = CNT_W'(1);
            end else if (per_cnt_q == CNT_MAX) begin
               sat_hit = 1'b1;
            end else begin
               per_cnt_d = per_cnt_q + 1'b1;
            end
         end
         MEAS: begin
            if (rise) begin
               per_cnt_d  = CNT_W'(1);
               high_cnt_d = CNT_W'(1);
               if (div_busy) begin
                  overrun_d = 1'b1;
               end else begin
                  dvs_d       = per_cnt_q;
                  rem_d       = {1'b0, high_cnt_q};
                  quo_d       = '0;
                  div_cnt_d   = DIV_ITERS;
                  per_hold_d  = per_cnt_q;
                  high_hold_d = high_cnt_q;
               end
            end else if (per_cnt_q == CNT_MAX) begin
               sat_hit = 1'b1;
            end else begin
               per_cnt_d  = per_cnt_q + 1'b1;
               high_cnt_d = high_cnt_q + CNT_W'(level);
            end
         end
         STUCK: begin
            if (rise) begin
               state_d      = MEAS;
               per_cnt_d    = CNT_W'(1);
               high_cnt_d   = CNT_W'(1);
               stuck_high_d = 1'b0;
               stuck_low_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (sat_hit) begin
         state_d      = STUCK;
         stuck_high_d = level;
         stuck_low_d  = ~level;
         duty_d       = level ? {WIDTH{1'b1}} : '0;
         period_d     = CNT_MAX;
         high_time_d  = level ? CNT_MAX : '0;
         valid_d      = 1'b1;
      end

      // Disabling drops any measurement in flight but keeps the last published result
      if (!enable) begin
         state_d      = IDLE;
         per_cnt_d    = '0;
         high_cnt_d   = '0;
         rem_d        = '0;
         quo_d        = '0;
         dvs_d        = '0;
         div_cnt_d    = '0;
         valid_d      = 1'b0;
         stuck_high_d = 1'b0;
         stuck_low_d  = 1'b0;
         overrun_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q       <= '0;
         lvl_q        <= 1'b0;
         per_cnt_q    <= '0;
         high_cnt_q   <= '0;
         per_hold_q   <= '0;
         high_hold_q  <= '0;
         dvs_q        <= '0;
         rem_q        <= '0;
         quo_q        <= '0;
         div_cnt_q    <= '0;
         duty_q       <= '0;
         period_q     <= '0;
         high_time_q  <= '0;
         valid_q      <= 1'b0;
         stuck_high_q <= 1'b0;
         stuck_low_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         sync_q       <= {sync_q[SYNC_STAGES-2:0], pwm_in};
         lvl_q        <= level;
         per_cnt_q    <= per_cnt_d;
         high_cnt_q   <= high_cnt_d;
         per_hold_q   <= per_hold_d;
         high_hold_q  <= high_hold_d;
         dvs_q        <= dvs_d;
         rem_q        <= rem_d;
         quo_q        <= quo_d;
         div_cnt_q    <= div_cnt_d;
         duty_q       <= duty_d;
         period_q     <= period_d;
         high_time_q  <= high_time_d;
         valid_q      <= valid_d;
         stuck_high_q <= stuck_high_d;
         stuck_low_q  <= stuck_low_d;
         overrun_q    <= overrun_d;
      end
   end

   assign duty_cycle = duty_q;
   assign period     = period_q;
   assign high_time  = high_time_q;
   assign valid      = valid_q;
   assign busy       = div_busy;
   assign stuck_high = stuck_high_q;
   assign stuck_low  = stuck_low_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (CNT_W=10 so stuck detection fits in a short run).
// Each task drives one scenario and compares outputs against hand-computed values.
module tb_pwm_capture;
   localparam int WIDTH = 8;
   localparam int CNT_W = 10;

   logic             clk = 1'b0;
   logic             reset, enable, pwm_in;
   logic [WIDTH-1:0] duty_cycle;
   logic [CNT_W-1:0] period, high_time;
   logic             valid, busy, stuck_high, stuck_low, overrun;

   int checks = 0, passed = 0;
   int cyc = 0, vcnt = 0, first_vcyc = -1, last_vcyc = -1;

   always #5 clk = ~clk;

   pwm_capture #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in),
      .duty_cycle(duty_cycle), .period(period), .high_time(high_time),
      .valid(valid), .busy(busy), .stuck_high(stuck_high),
      .stuck_low(stuck_low), .overrun(overrun)
   );

   // Advance one clock and sample just after the edge, logging valid pulses
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (valid) begin
         vcnt++;
         if (first_vcyc < 0) first_vcyc = cyc;
         last_vcyc = cyc;
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic clr_stats();
      vcnt = 0; first_vcyc = -1; last_vcyc = -1;
   endtask

   task automatic run_pwm(input int per, input int hi, input int np);
      for (int p = 0; p < np; p++)
         for (int i = 0; i < per; i++) begin
            pwm_in = (i < hi);
            tick();
         end
   endtask

   task automatic do_reset();
      reset = 1'b1; enable = 1'b0; pwm_in = 1'b0;
      ticks(2);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (duty_cycle !== 8'd0) $display("FAIL reset_duty: got %0d want 0", duty_cycle); else passed++;
      checks++; if (period !== 10'd0) $display("FAIL reset_period: got %0d want 0", period); else passed++;
      checks++; if (high_time !== 10'd0) $display("FAIL reset_high: got %0d want 0", high_time); else passed++;
      checks++; if ({valid, busy, stuck_high, stuck_low, overrun} !== 5'b0)
         $display("FAIL reset_flags: got %b want 00000", {valid, busy, stuck_high, stuck_low, overrun}); else passed++;
   endtask

   task automatic test_duty64();
      int n;
      enable = 1'b1;
      ticks(3);
      clr_stats();
      n = cyc;
      run_pwm(256, 64, 3);
      pwm_in = 1'b0;
      ticks(20);
      checks++; if (period !== 10'd256) $display("FAIL d64_period: got %0d want 256", period); else passed++;
      checks++; if (high_time !== 10'd64) $display("FAIL d64_high: got %0d want 64", high_time); else passed++;
      checks++; if (duty_cycle !== 8'd64) $display("FAIL d64_duty: got %0d want 64", duty_cycle); else passed++;
      checks++; if (vcnt !== 2) $display("FAIL d64_vcnt: got %0d want 2", vcnt); else passed++;
      checks++; if (first_vcyc !== n + 268) $display("FAIL d64_latency: got %0d want %0d", first_vcyc - n, 268); else passed++;
      checks++; if (last_vcyc - first_vcyc !== 256) $display("FAIL d64_spacing: got %0d want 256", last_vcyc - first_vcyc); else passed++;
   endtask

   task automatic test_sweep();
      int duties [3] = '{1, 128, 254};
      for (int k = 0; k < 3; k++) begin
         clr_stats();
         run_pwm(256, duties[k], 2);
         checks++; if (duty_cycle !== 8'(duties[k])) $display("FAIL sweep_duty%0d: got %0d want %0d", duties[k], duty_cycle, duties[k]); else passed++;
         checks++; if (high_time !== 10'(duties[k])) $display("FAIL sweep_high%0d: got %0d want %0d", duties[k], high_time, duties[k]); else passed++;
      end
      checks++; if (overrun !== 1'b0) $display("FAIL sweep_overrun: got %b want 0", overrun); else passed++;
   endtask

   task automatic test_synthetic_overrun();
      run_pwm(100, 33, 3);
      checks++; if (duty_cycle !== 8'd84) $display("FAIL syn_duty: got %0d want 84", duty_cycle); else passed++;
      checks++; if (period !== 10'd100) $display("FAIL syn_period: got %0d want 100", period); else passed++;
      clr_stats();
      run_pwm(8, 3, 4);
      pwm_in = 1'b0;
      ticks(20);
      checks++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun); else passed++;
      checks++; if (vcnt !== 2) $display("FAIL ovr_vcnt: got %0d want 2", vcnt); else passed++;
      checks++; if (period !== 10'd8) $display("FAIL ovr_period: got %0d want 8", period); else passed++;
      checks++; if (duty_cycle !== 8'd96) $display("FAIL ovr_duty: got %0d want 96", duty_cycle); else passed++;
   endtask

   task automatic test_stuck_high();
      int k = 0;
      do_reset();
      enable = 1'b1; pwm_in = 1'b1;
      clr_stats();
      while (!stuck_high && k < 1100) begin tick(); k++; end
      checks++; if (k < 1023 || k > 1030) $display("FAIL sh_timeout: got %0d clocks want 1023..1030", k); else passed++;
      ticks(50);
      checks++; if (stuck_low !== 1'b0) $display("FAIL sh_low_flag: got %b want 0", stuck_low); else passed++;
      checks++; if (duty_cycle !== 8'd255) $display("FAIL sh_duty: got %0d want 255", duty_cycle); else passed++;
      checks++; if (period !== 10'd1023 || high_time !== 10'd1023)
         $display("FAIL sh_period_high: got %0d/%0d want 1023/1023", period, high_time); else passed++;
      checks++; if (vcnt !== 1) $display("FAIL sh_vcnt: got %0d want 1", vcnt); else passed++;
      pwm_in = 1'b0; ticks(5);
      pwm_in = 1'b1; ticks(5);
      checks++; if (stuck_high !== 1'b0) $display("FAIL sh_clear: got %b want 0", stuck_high); else passed++;
      checks++; if (vcnt !== 1) $display("FAIL sh_partial_vcnt: got %0d want 1", vcnt); else passed++;
   endtask

   task automatic test_stuck_low();
      int k = 0;
      do_reset();
      enable = 1'b1; pwm_in = 1'b0;
      while (!stuck_low && k < 1100) begin tick(); k++; end
      checks++; if (k < 1023 || k > 1030) $display("FAIL sl_timeout: got %0d clocks want 1023..1030", k); else passed++;
      checks++; if (stuck_high !== 1'b0) $display("FAIL sl_high_flag: got %b want 0", stuck_high); else passed++;
      checks++; if (duty_cycle !== 8'd0) $display("FAIL sl_duty: got %0d want 0", duty_cycle); else passed++;
      checks++; if (period !== 10'd1023) $display("FAIL sl_period: got %0d want 1023", period); else passed++;
      checks++; if (high_time !== 10'd0) $display("FAIL sl_high: got %0d want 0", high_time); else passed++;
   endtask

   task automatic test_reset_mid_div();
      clr_stats();
      run_pwm(100, 33, 1);
      pwm_in = 1'b1;
      ticks(6);
      checks++; if (busy !== 1'b1) $display("FAIL rmd_busy: got %b want 1", busy); else passed++;
      reset = 1'b1;
      tick();
      reset = 1'b0; pwm_in = 1'b0;
      ticks(20);
      checks++; if (vcnt !== 0) $display("FAIL rmd_vcnt: got %0d want 0", vcnt); else passed++;
      checks++; if (period !== 10'd0 || high_time !== 10'd0)
         $display("FAIL rmd_period_high: got %0d/%0d want 0/0", period, high_time); else passed++;
      checks++; if (duty_cycle !== 8'd0) $display("FAIL rmd_duty: got %0d want 0", duty_cycle); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL rmd_idle_busy: got %b want 0", busy); else passed++;
   endtask

   task automatic test_disable();
      run_pwm(100, 33, 3);
      run_pwm(8, 3, 2);
      pwm_in = 1'b0;
      ticks(20);
      checks++; if (overrun !== 1'b1) $display("FAIL dis_pre_overrun: got %b want 1", overrun); else passed++;
      enable = 1'b0;
      ticks(2);
      checks++; if (period !== 10'd100 || high_time !== 10'd33)
         $display("FAIL dis_hold_period_high: got %0d/%0d want 100/33", period, high_time); else passed++;
      checks++; if (duty_cycle !== 8'd84) $display("FAIL dis_hold_duty: got %0d want 84", duty_cycle); else passed++;
      checks++; if (overrun !== 1'b0) $display("FAIL dis_overrun: got %b want 0", overrun); else passed++;
      checks++; if ({valid, busy, stuck_high, stuck_low} !== 4'b0)
         $display("FAIL dis_flags: got %b want 0000", {valid, busy, stuck_high, stuck_low}); else passed++;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; pwm_in = 1'b0;
      test_reset();
      test_duty64();
      test_sweep();
      test_synthetic_overrun();
      test_stuck_high();
      test_stuck_low();
      test_reset_mid_div();
      test_disable();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
